// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage RV32I pipeline.
// Prioritised hazard resolution, memory-wait watchdog and stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_mem_re,
    input  logic             ex_jump_en,
    input  logic [31:0]      ex_jump_addr,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             trap_en,
    input  logic [31:0]      trap_addr,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             redirect_en,
    output logic [31:0]      redirect_addr,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ABORT} state_t;

    state_t      state, state_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic [16:0] waited;
    logic        load_use, mem_stall, expire;

    always_comb begin
        load_use = ex_mem_re && (ex_rd_addr != 5'd0) &&
                   ((id_rs1_used && (id_rs1_addr == ex_rd_addr)) ||
                    (id_rs2_used && (id_rs2_addr == ex_rd_addr)));
        mem_stall = mem_req && !mem_ready && (state != ABORT);
        // Held cycles of this access counting the current one; the access is
        // abandoned once MEM_TIMEOUT of them have elapsed without mem_ready.
        waited = (state == MEM_WAIT) ? ({1'b0, wait_cnt} + 17'd1) : 17'd1;
        expire = mem_stall && (waited == 17'(MEM_TIMEOUT));

        pc_hold       = 1'b0;
        ifid_hold     = 1'b0;
        idex_hold     = 1'b0;
        exmem_hold    = 1'b0;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        exmem_flush   = 1'b0;
        memwb_flush   = 1'b0;
        redirect_en   = 1'b0;
        redirect_addr = '0;
        bus_err       = 1'b0;
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;

        if (trap_en) begin
            redirect_en   = 1'b1;
            redirect_addr = trap_addr;
            ifid_flush    = 1'b1;
            idex_flush    = 1'b1;
            exmem_flush   = 1'b1;
            state_nxt     = RUN;
            wait_cnt_nxt  = '0;
        end else if (state == ABORT) begin
            bus_err      = 1'b1;
            exmem_flush  = 1'b1;
            memwb_flush  = 1'b1;
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
        end else if (mem_stall) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_hold   = 1'b1;
            exmem_hold  = 1'b1;
            memwb_flush = 1'b1;
            if (expire) begin
                state_nxt    = ABORT;
                wait_cnt_nxt = '0;
            end else if (state == RUN) begin
                state_nxt    = MEM_WAIT;
                wait_cnt_nxt = 16'd1;
            end else begin
                wait_cnt_nxt = wait_cnt + 16'd1;
            end
        end else begin
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
            if (ex_jump_en) begin
                redirect_en   = 1'b1;
                redirect_addr = ex_jump_addr;
                ifid_flush    = 1'b1;
                idex_flush    = 1'b1;
            end else if (load_use) begin
                pc_hold    = 1'b1;
                ifid_hold  = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (pc_hold) begin
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus a random run,
// all checked against a cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int unsigned T  = 4;
    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic          id_rs1_used, id_rs2_used, ex_mem_re, ex_jump_en;
    logic [31:0]   ex_jump_addr, trap_addr, redirect_addr;
    logic          mem_req, mem_ready, trap_en;
    logic          pc_hold, ifid_hold, idex_hold, exmem_hold;
    logic          ifid_flush, idex_flush, exmem_flush, memwb_flush;
    logic          redirect_en, bus_err;
    logic [CW-1:0] stall_cnt;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_addr(ex_rd_addr), .ex_mem_re(ex_mem_re),
        .ex_jump_en(ex_jump_en), .ex_jump_addr(ex_jump_addr),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .trap_en(trap_en), .trap_addr(trap_addr),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold),
        .exmem_hold(exmem_hold), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rs1, rs2;
        logic        rs1u, rs2u;
        logic [4:0]  exrd;
        logic        memre, jmp;
        logic [31:0] jaddr;
        logic        req, rdy, trap;
        logic [31:0] taddr;
    } in_t;

    // ctl bit order: pc_hold ifid_hold idex_hold exmem_hold ifid_flush
    //                idex_flush exmem_flush memwb_flush redirect_en bus_err
    typedef struct packed {
        logic [9:0]  ctl;
        logic [31:0] addr;
    } exp_t;

    int unsigned   n_checks = 0;
    int unsigned   n_err    = 0;
    int unsigned   m_age    = 0;
    bit            m_abort  = 1'b0;
    logic [CW-1:0] m_scnt   = '0;

    function automatic logic [9:0] ctl_now();
        return {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush,
                idex_flush, exmem_flush, memwb_flush, redirect_en, bus_err};
    endfunction

    function automatic in_t idle();
        in_t v;
        v = '0;
        return v;
    endfunction

    task automatic apply(input in_t v);
        id_rs1_addr = v.rs1;   id_rs2_addr  = v.rs2;
        id_rs1_used = v.rs1u;  id_rs2_used  = v.rs2u;
        ex_rd_addr  = v.exrd;  ex_mem_re    = v.memre;
        ex_jump_en  = v.jmp;   ex_jump_addr = v.jaddr;
        mem_req     = v.req;   mem_ready    = v.rdy;
        trap_en     = v.trap;  trap_addr    = v.taddr;
    endtask

    // Expected outputs this cycle from the priority rules and the model's abort flag.
    function automatic exp_t model_eval(input in_t v);
        exp_t e;
        logic hit;
        hit = v.memre && v.exrd != 0 &&
              ((v.rs1u && v.rs1 == v.exrd) || (v.rs2u && v.rs2 == v.exrd));
        e = '0;
        if (v.trap)                  begin e.ctl = 10'b0000111010; e.addr = v.taddr; end
        else if (m_abort)            e.ctl = 10'b0000001101;
        else if (v.req && !v.rdy)    e.ctl = 10'b1111000100;
        else if (v.jmp)              begin e.ctl = 10'b0000110010; e.addr = v.jaddr; end
        else if (hit)                e.ctl = 10'b1100010000;
        return e;
    endfunction

    // Advance the model: count consecutive held cycles of an access; after T of
    // them without ready the next cycle is the abort cycle.
    task automatic model_commit(input in_t v, input exp_t e);
        if (e.ctl[9]) m_scnt = m_scnt + 1'b1;
        if (v.trap) begin
            m_age = 0; m_abort = 1'b0;
        end else if (m_abort) begin
            m_abort = 1'b0; m_age = 0;
        end else if (v.req && !v.rdy) begin
            m_age++;
            if (m_age == T) begin m_abort = 1'b1; m_age = 0; end
        end else begin
            m_age = 0;
        end
    endtask

    task automatic model_reset();
        m_age = 0; m_abort = 1'b0; m_scnt = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply(idle());
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(idle());
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        n_checks += 3;
        if (ctl_now() !== 10'b0) begin n_err++; $display("FAIL reset ctl got=%b exp=%b", ctl_now(), 10'b0); end
        if (redirect_addr !== 32'h0) begin n_err++; $display("FAIL reset addr got=%h exp=0", redirect_addr); end
        if (stall_cnt !== '0) begin n_err++; $display("FAIL reset stall_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_load_use();
        in_t q[$];
        in_t v;
        exp_t e;
        v = idle(); v.memre = 1; v.exrd = 5; v.rs1 = 5; v.rs1u = 1; q.push_back(v);
        v = idle(); q.push_back(v);
        v = idle(); v.memre = 1; v.exrd = 0; v.rs1 = 0; v.rs1u = 1; q.push_back(v);
        v = idle(); v.memre = 1; v.exrd = 5; v.rs1 = 5; v.rs1u = 0; q.push_back(v);
        v = idle(); v.memre = 1; v.exrd = 9; v.rs2 = 9; v.rs2u = 1; q.push_back(v);
        v = idle(); v.memre = 0; v.exrd = 9; v.rs2 = 9; v.rs2u = 1; q.push_back(v);
        foreach (q[i]) begin
            @(negedge clk); apply(q[i]); #1;
            e = model_eval(q[i]);
            n_checks += 3;
            if (ctl_now() !== e.ctl) begin n_err++; $display("FAIL load_use[%0d] ctl got=%b exp=%b", i, ctl_now(), e.ctl); end
            if (redirect_addr !== e.addr) begin n_err++; $display("FAIL load_use[%0d] addr got=%h exp=%h", i, redirect_addr, e.addr); end
            if (stall_cnt !== m_scnt) begin n_err++; $display("FAIL load_use[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, m_scnt); end
            @(posedge clk); model_commit(q[i], e);
        end
    endtask

    task automatic test_branch();
        in_t v;
        @(negedge clk);
        v = idle(); v.jmp = 1; v.jaddr = 32'h0000_0100;
        apply(v); #1;
        n_checks += 2;
        if (ctl_now() !== 10'b0000110010) begin n_err++; $display("FAIL branch ctl got=%b exp=%b", ctl_now(), 10'b0000110010); end
        if (redirect_addr !== 32'h100) begin n_err++; $display("FAIL branch addr got=%h exp=%h", redirect_addr, 32'h100); end
        @(posedge clk); model_commit(v, model_eval(v));
    endtask

    task automatic test_mem_wait();
        in_t v;
        exp_t e;
        logic [CW-1:0] start;
        int unsigned held = 0;
        start = m_scnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            v = idle(); v.req = (i < 4); v.rdy = (i == 3);
            apply(v); #1;
            e = model_eval(v);
            if (pc_hold) held++;
            n_checks += 2;
            if (ctl_now() !== e.ctl) begin n_err++; $display("FAIL mem_wait[%0d] ctl got=%b exp=%b", i, ctl_now(), e.ctl); end
            if (stall_cnt !== m_scnt) begin n_err++; $display("FAIL mem_wait[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, m_scnt); end
            @(posedge clk); model_commit(v, e);
        end
        n_checks += 2;
        if (held != 3) begin n_err++; $display("FAIL mem_wait held got=%0d exp=3", held); end
        if (stall_cnt !== CW'(start + 3)) begin n_err++; $display("FAIL mem_wait delta got=%0d exp=%0d", stall_cnt, CW'(start + 3)); end
    endtask

    task automatic test_timeout();
        in_t v;
        exp_t e;
        logic [9:0] seen [8];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v = idle(); v.req = (i < 6);
            apply(v); #1;
            e = model_eval(v);
            seen[i] = ctl_now();
            n_checks++;
            if (ctl_now() !== e.ctl) begin n_err++; $display("FAIL timeout[%0d] ctl got=%b exp=%b", i, ctl_now(), e.ctl); end
            @(posedge clk); model_commit(v, e);
        end
        n_checks += 3;
        if (seen[3] !== 10'b1111000100) begin n_err++; $display("FAIL timeout last_hold got=%b exp=%b", seen[3], 10'b1111000100); end
        if (seen[4] !== 10'b0000001101) begin n_err++; $display("FAIL timeout abort got=%b exp=%b", seen[4], 10'b0000001101); end
        if (seen[5] !== 10'b1111000100) begin n_err++; $display("FAIL timeout new_access got=%b exp=%b", seen[5], 10'b1111000100); end
    endtask

    task automatic test_ready_at_limit();
        in_t v;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            v = idle(); v.req = (i < 4); v.rdy = (i == 3);
            apply(v); #1;
            e = model_eval(v);
            n_checks++;
            if (ctl_now() !== e.ctl || bus_err !== 1'b0) begin n_err++; $display("FAIL ready_limit[%0d] ctl got=%b exp=%b", i, ctl_now(), e.ctl); end
            @(posedge clk); model_commit(v, e);
        end
    endtask

    task automatic test_simultaneous();
        in_t q[$];
        in_t v;
        exp_t e;
        v = idle(); v.req = 1; q.push_back(v);
        v = idle(); v.req = 1; v.jmp = 1; v.jaddr = 32'h200; v.trap = 1; v.taddr = 32'h8000_0040; q.push_back(v);
        v = idle(); v.req = 1; q.push_back(v);
        v = idle(); v.req = 1; q.push_back(v);
        v = idle(); v.req = 1; q.push_back(v);
        v = idle(); v.jmp = 1; v.jaddr = 32'h300; v.memre = 1; v.exrd = 7; v.rs2 = 7; v.rs2u = 1; q.push_back(v);
        v = idle(); v.req = 1; v.jmp = 1; v.jaddr = 32'h400; v.memre = 1; v.exrd = 3; v.rs1 = 3; v.rs1u = 1; q.push_back(v);
        v = idle(); v.req = 1; v.rdy = 1; v.jmp = 1; v.jaddr = 32'h400; q.push_back(v);
        foreach (q[i]) begin
            @(negedge clk); apply(q[i]); #1;
            e = model_eval(q[i]);
            n_checks += 2;
            if (ctl_now() !== e.ctl) begin n_err++; $display("FAIL simul[%0d] ctl got=%b exp=%b", i, ctl_now(), e.ctl); end
            if (redirect_addr !== e.addr) begin n_err++; $display("FAIL simul[%0d] addr got=%h exp=%h", i, redirect_addr, e.addr); end
            @(posedge clk); model_commit(q[i], e);
        end
    endtask

    task automatic test_reset_mid_wait();
        in_t v;
        exp_t e;
        v = idle(); v.req = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); apply(v); #1;
            e = model_eval(v);
            @(posedge clk); model_commit(v, e);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply(idle());
        model_reset();
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks += 2;
            if (ctl_now() !== 10'b0) begin n_err++; $display("FAIL rst_wait[%0d] ctl got=%b exp=%b", i, ctl_now(), 10'b0); end
            if (stall_cnt !== '0) begin n_err++; $display("FAIL rst_wait[%0d] stall_cnt got=%0d exp=0", i, stall_cnt); end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        in_t v;
        exp_t e;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.rs1u  = 1'($urandom);
            v.rs2u  = 1'($urandom);
            v.exrd  = 5'($urandom_range(0, 3));
            v.memre = 1'($urandom);
            v.jmp   = ($urandom_range(0, 4) == 0);
            v.jaddr = $urandom;
            v.req   = ($urandom_range(0, 9) < 5);
            v.rdy   = ($urandom_range(0, 9) < 3);
            v.trap  = ($urandom_range(0, 29) == 0);
            v.taddr = $urandom;
            apply(v); #1;
            e = model_eval(v);
            n_checks += 4;
            if (ctl_now() !== e.ctl) begin n_err++; $display("FAIL random[%0d] ctl got=%b exp=%b", i, ctl_now(), e.ctl); end
            if (redirect_addr !== e.addr) begin n_err++; $display("FAIL random[%0d] addr got=%h exp=%h", i, redirect_addr, e.addr); end
            if (stall_cnt !== m_scnt) begin n_err++; $display("FAIL random[%0d] stall_cnt got=%0d exp=%0d", i, stall_cnt, m_scnt); end
            if ((ifid_hold && ifid_flush) || (idex_hold && idex_flush) || (exmem_hold && exmem_flush)) begin
                n_err++; $display("FAIL random[%0d] hold_and_flush got=%b exp=exclusive", i, ctl_now());
            end
            @(posedge clk); model_commit(v, e);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_timeout();
        test_ready_at_limit();
        test_simultaneous();
        test_reset_mid_wait();
        do_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
